// File: rtl/elastic_buffer_if.sv
// Valid/ready bundle for one elastic buffer: producer side (valid_in/data_in/ready_out)
// and consumer side (valid_out/data_out/ready_in).
interface elastic_buffer_if #(
  parameter type T = logic [31:0]
);
  // A beat transfers on a rising edge where the sender's valid and the receiver's
  // ready are both high; a sender may not withdraw valid or change data until then.
  logic valid_in;
  logic ready_out;
  T     data_in;
  logic valid_out;
  logic ready_in;
  T     data_out;

  modport slave (
    input  valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out
  );

  modport master (
    output valid_in, data_in, ready_in,
    input  ready_out, valid_out, data_out
  );
endinterface

// File: rtl/elastic_buffer.sv
// DEPTH-entry elastic buffer with optional fall-through, synchronous flush and occupancy
// count; ready_out depends only on internal state and flush.
module elastic_buffer #(
  parameter type T           = logic [31:0],
  parameter int  DEPTH       = 2,
  parameter bit  FALLTHROUGH = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  elastic_buffer_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          empty;
  logic          full;
  logic          bypass;
  logic          push;
  logic          pop;

  always_comb begin
    empty         = (count_q == '0);
    full          = (count_q == FULL_CNT);
    bus.ready_out = !flush && !full;
    // An empty fall-through buffer hands the beat straight to the consumer without storing it.
    bypass        = FALLTHROUGH && empty && bus.valid_in && bus.ready_in && !flush;
    push          = bus.valid_in && bus.ready_out && !bypass;
    pop           = bus.ready_in && !empty && !flush;
    if (flush) begin
      bus.valid_out = 1'b0;
    end else if (!empty) begin
      bus.valid_out = 1'b1;
    end else begin
      bus.valid_out = FALLTHROUGH && bus.valid_in;
    end
    bus.data_out = (FALLTHROUGH && empty) ? bus.data_in : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.data_in;
        // Explicit wrap so non-power-of-two depths cycle correctly.
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign count = count_q;
endmodule

// File: doc/elastic_buffer.md
# elastic_buffer

Parametrised elastic buffer for valid/ready pipeline stages between front-end, rename and dispatch. It generalises the single-entry skid stage to DEPTH entries, a selectable fall-through or registered output, a synchronous flush for branch-mispredict recovery and an occupancy count. ready_out is driven only from internal state, so the block breaks the combinational ready path between consumer and producer.

## Interface
- T, logic [31:0]: payload type (any packed type, struct allowed).
- DEPTH, 2: number of storage entries; legal range 1..64, non-power-of-2 allowed.
- FALLTHROUGH, 1: 1 = empty buffer passes data_in to data_out combinationally (0-cycle latency); 0 = registered output (1-cycle minimum latency).
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all contents (mispredict).
- valid_in  in  1  producer has data.
- ready_out  out  1  buffer accepts data this cycle.
- data_in  in  T  producer payload.
- valid_out  out  1  buffer presents data.
- ready_in  in  1  consumer accepts data.
- data_out  out  T  payload to consumer.
- count  out  $clog2(DEPTH+1)  stored entries (bypassed beats excluded).

## Operation
- Storage: circular array of DEPTH entries with rd_ptr and wr_ptr, each $clog2(DEPTH) bits (minimum 1), plus an explicit count register. Full/empty come from count, never from pointer comparison.
- Pointer increment wraps from DEPTH-1 to 0; the wrap is explicit so non-power-of-2 DEPTH works.
- ready_out = !flush && (count < DEPTH). It never depends on ready_in or valid_in.
- valid_out:
  - flush high: 0.
  - count > 0: 1.
  - count == 0: valid_in if FALLTHROUGH=1, otherwise 0.
- data_out:
  - count > 0: the entry at rd_ptr.
  - count == 0 and FALLTHROUGH=1: data_in.
  - count == 0 and FALLTHROUGH=0: the entry at rd_ptr (content don't-care).
- bypass = FALLTHROUGH && count==0 && valid_in && ready_in && !flush. A bypassed beat is never written.
- push = valid_in && ready_out && !bypass. push writes data_in at wr_ptr and advances wr_ptr.
- pop = ready_in && count>0 && !flush. pop advances rd_ptr.
- count_next = count + push - pop. Simultaneous push and pop leave count unchanged.
- When full, ready_out=0, so no push occurs even if a pop happens in the same cycle. Throughput at full is one beat every other cycle only when DEPTH=1. For DEPTH>=2, a steady stream with ready_in=1 never fills the buffer.
- Ordering is strictly FIFO, and every accepted beat is delivered exactly once unless flushed.
- flush: count, rd_ptr and wr_ptr go to 0 at the next edge. The valid_in beat in the flush cycle is discarded, and no handshake completes in that cycle.
- Priority: reset > flush > push/pop.

## Timing
- Reset values (next edge after reset=1): count=0, rd_ptr=0, wr_ptr=0, all storage entries '0. Consequently ready_out=1, valid_out=0 (FALLTHROUGH=0) or valid_out=valid_in (FALLTHROUGH=1), and data_out='0 (FALLTHROUGH=0).
- Reset mid-operation drops all contents with no beat delivered afterward.
- Latency, FALLTHROUGH=1 and empty: 0 cycles. Otherwise a beat pushed at edge N is visible on data_out from cycle N+1 at the earliest.
- Combinational paths:
  - flush reaches ready_out and valid_out.
  - With FALLTHROUGH=1: valid_in/data_in reach valid_out/data_out.
  - No path from ready_in to ready_out under any configuration.
- A handshake occurs on a cycle with valid && ready at the rising edge. valid_out, once high, stays high with data_out stable until a pop or flush. The exception is the FALLTHROUGH=1 empty case, where valid_out follows valid_in.

## Test plan
- Reset/idle, DEPTH=2, FALLTHROUGH=1: hold reset 2 cycles, then release with valid_in=0 → ready_out=1, valid_out=0, count=0. Then valid_in=1, data_in=0xA5, ready_in=1 → data_out=0xA5 in the same cycle, and count stays 0.
- Backpressure fill, DEPTH=3, FALLTHROUGH=0:
  - With ready_in=0, push 0x11, 0x22, 0x33 → count=3, ready_out=0 after the third push.
  - A fourth beat 0x44 is held by the producer; count stays 3.
  - With ready_in=1 → outputs 0x11, 0x22, 0x33, 0x44 in order.
- Wrap-around, DEPTH=3 (non-power-of-2): stream 10 beats 0..9 with ready_in toggling 1,0,1,0… → all 10 beats delivered in order, pointers wrap 2→0 correctly, count never exceeds 3.
- Simultaneous push/pop at count=1, DEPTH=2: valid_in=1 and ready_in=1 for 5 cycles → count stays 1 and one beat is delivered per cycle with no gaps.
- Flush, DEPTH=4: load 0x1..0x3 (count=3), then assert flush with valid_in=1, data_in=0x9 for 1 cycle.
  - During the flush cycle: valid_out=0, ready_out=0.
  - Next cycle: count=0, and 0x9 is never delivered.
  - A following push of 0x5 is delivered first.
- Reset mid-stream, DEPTH=2: assert reset with count=2 → next cycle count=0, ready_out=1, and neither stored beat appears at data_out.
